issue_select: RTL and testbench

Oldest-first select stage that sits directly downstream of the wakeup logic in the backend scheduler. It consumes the per-row `request_vector` and keeps a per-row age matrix, updated from scheduler allocations. Each cycle the functional unit can accept an instruction, it grants the oldest requesting valid row. The grant is returned as a registered row index, with `free_en`/`free_row_index` fed back to the wakeup logic to release the row.

---
 rtl/issue_select_pkg.sv | 15 +
 rtl/issue_select_age_matrix.sv | 118 +++++++++++
 rtl/issue_select.sv | 96 +++++++++
 tb/tb_issue_select.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
//------------------------------------------------------------------------------
// Module  : issue_select_pkg
// Brief   : Shared scheduler constants for the oldest-first issue select stage.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package issue_select_pkg;

  // Number of scheduler rows tracked by the select stage.
  localparam int unsigned C_SCHED_ROWS = 8;

endpackage : issue_select_pkg

`default_nettype wire

// File: rtl/issue_select_age_matrix.sv
//------------------------------------------------------------------------------
// Module  : age_matrix
// Brief   : Per-row valid bits and pairwise age matrix; exports a one-hot
//           vector selecting the oldest valid, requesting row.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module age_matrix
  import issue_select_pkg::*;
#(
  parameter int unsigned NUM_ROWS = C_SCHED_ROWS,
  parameter int unsigned IDX_W    = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en_i,
  input  logic [IDX_W-1:0]    alloc_idx_i,
  input  logic [NUM_ROWS-1:0] request_i,
  input  logic                dealloc_en_i,
  input  logic [NUM_ROWS-1:0] dealloc_oh_i,
  input  logic                flush_i,
  output logic [NUM_ROWS-1:0] oldest_oh_o,
  output logic                alloc_err_o
);

  // age_q[i][j] = 1 means row i is older than row j
  logic [NUM_ROWS-1:0] valid_q, valid_d;
  logic [NUM_ROWS-1:0] age_q [NUM_ROWS];
  logic [NUM_ROWS-1:0] age_d [NUM_ROWS];
  logic                alloc_err_q, alloc_err_d;

  logic [NUM_ROWS-1:0] elig;
  logic [NUM_ROWS-1:0] valid_after_free;
  logic                alloc_ok;
  logic                alloc_bad;

  // A row that was just granted drops out of valid, which masks its
  // still-asserted request until the wakeup logic frees it.
  assign elig = request_i & valid_q;

  // A row wins when no other eligible row is older than it (column i clear).
  generate
    for (genvar i = 0; i < NUM_ROWS; i++) begin : g_oldest
      logic [NUM_ROWS-1:0] col;
      for (genvar j = 0; j < NUM_ROWS; j++) begin : g_col
        assign col[j] = age_q[j][i];
      end
      assign oldest_oh_o[i] = elig[i] & ~|(elig & col);
    end
  endgenerate

  // Allocation onto a still-valid row (including the row being granted
  // this cycle) is rejected and flagged; flush suppresses allocation.
  assign alloc_ok  = alloc_en_i & ~valid_q[alloc_idx_i] & ~flush_i;
  assign alloc_bad = alloc_en_i &  valid_q[alloc_idx_i] & ~flush_i;

  assign valid_after_free = dealloc_en_i ? (valid_q & ~dealloc_oh_i) : valid_q;

  // Next-state valid bits: free the granted row, then set the allocated one.
  always_comb begin
    valid_d = valid_after_free;
    if (alloc_ok) begin
      valid_d[alloc_idx_i] = 1'b1;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  // Next-state age matrix: clear granted row/column, make the new row the
  // youngest relative to every row that survives this cycle.
  always_comb begin
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_ROWS; j++) begin
        age_d[i][j] = age_q[i][j];
        if (dealloc_en_i && (dealloc_oh_i[i] || dealloc_oh_i[j])) begin
          age_d[i][j] = 1'b0;
        end
        if (alloc_ok) begin
          if (i == int'(alloc_idx_i)) begin
            age_d[i][j] = 1'b0;
          end else if (j == int'(alloc_idx_i)) begin
            age_d[i][j] = valid_after_free[i];
          end
        end
        if (i == j || flush_i) begin
          age_d[i][j] = 1'b0;
        end
      end
    end
  end

  // Sticky error flag: only reset clears it.
  assign alloc_err_d = alloc_err_q | alloc_bad;

  // State registers for valid, age and the error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      alloc_err_q <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      alloc_err_q <= alloc_err_d;
      for (int i = 0; i < NUM_ROWS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign alloc_err_o = alloc_err_q;

endmodule : age_matrix

`default_nettype wire

// File: rtl/issue_select.sv
//------------------------------------------------------------------------------
// Module  : issue_select
// Brief   : Oldest-first issue select. Grants the oldest requesting valid row
//           when the functional unit is ready and returns it as a registered
//           row index, mirrored on the free interface back to wakeup.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module issue_select
  import issue_select_pkg::*;
#(
  parameter  int unsigned NUM_ROWS = C_SCHED_ROWS,
  localparam int unsigned IDX_W    = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_en,
  input  logic [IDX_W-1:0]    alloc_row_index,
  input  logic [NUM_ROWS-1:0] request_vector,
  input  logic                fu_ready,
  input  logic                flush,
  output logic                issue_valid,
  output logic [IDX_W-1:0]    issue_row_index,
  output logic                free_en,
  output logic [IDX_W-1:0]    free_row_index,
  output logic                alloc_err
);

  logic [NUM_ROWS-1:0] oldest_oh;
  logic                grant;
  logic [IDX_W-1:0]    win_idx;

  logic                issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]    issue_row_q, issue_row_d;

  // Flush discards any grant computed in the same cycle.
  assign grant = fu_ready & (|oldest_oh) & ~flush;

  age_matrix #(
    .NUM_ROWS (NUM_ROWS),
    .IDX_W    (IDX_W)
  ) u_age_matrix (
    .clk          (clk),
    .rst          (rst),
    .alloc_en_i   (alloc_en),
    .alloc_idx_i  (alloc_row_index),
    .request_i    (request_vector),
    .dealloc_en_i (grant),
    .dealloc_oh_i (oldest_oh),
    .flush_i      (flush),
    .oldest_oh_o  (oldest_oh),
    .alloc_err_o  (alloc_err)
  );

  // One-hot to index encoder; the select guarantees at most one bit set.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (oldest_oh[i]) begin
        win_idx = win_idx | IDX_W'(i);
      end
    end
  end

  // Output register next state: index holds when nothing is granted.
  always_comb begin
    issue_valid_d = 1'b0;
    issue_row_d   = issue_row_q;
    if (flush) begin
      issue_row_d = '0;
    end else if (grant) begin
      issue_valid_d = 1'b1;
      issue_row_d   = win_idx;
    end
  end

  // Registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      issue_row_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_row_q   <= issue_row_d;
    end
  end

  assign issue_valid     = issue_valid_q;
  assign issue_row_index = issue_row_q;
  assign free_en         = issue_valid_q;
  assign free_row_index  = issue_row_q;

endmodule : issue_select

`default_nettype wire

// File: tb/tb_issue_select.sv
//------------------------------------------------------------------------------
// Module  : tb_issue_select
// Brief   : Self-checking bench for issue_select: directed scenarios followed
//           by randomized traffic, compared against an allocation-timestamp
//           reference model (oldest = smallest allocation sequence number).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_issue_select;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alloc_en = 1'b0;
  logic [W-1:0] alloc_row_index = '0;
  logic [N-1:0] request_vector = '0;
  logic         fu_ready = 1'b0;
  logic         flush = 1'b0;
  logic         issue_valid;
  logic [W-1:0] issue_row_index;
  logic         free_en;
  logic [W-1:0] free_row_index;
  logic         alloc_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit mv [N];
  int ts [N];
  int seq;
  bit m_iv;
  int m_idx;
  bit m_err;

  issue_select #(.NUM_ROWS(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_en        (alloc_en),
    .alloc_row_index (alloc_row_index),
    .request_vector  (request_vector),
    .fu_ready        (fu_ready),
    .flush           (flush),
    .issue_valid     (issue_valid),
    .issue_row_index (issue_row_index),
    .free_en         (free_en),
    .free_row_index  (free_row_index),
    .alloc_err       (alloc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    int  w;
    bit  legal;
    if (rst) begin
      foreach (mv[i]) begin mv[i] = 0; ts[i] = 0; end
      m_iv = 0; m_idx = 0; m_err = 0;
    end else if (flush) begin
      foreach (mv[i]) mv[i] = 0;
      m_iv = 0; m_idx = 0;
    end else begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (request_vector[i] && mv[i] && (w < 0 || ts[i] < ts[w])) w = i;
      legal = 0;
      if (alloc_en) begin
        if (mv[alloc_row_index]) m_err = 1;
        else legal = 1;
      end
      if (fu_ready && w >= 0) begin
        mv[w] = 0; m_iv = 1; m_idx = w;
      end else begin
        m_iv = 0;
      end
      if (legal) begin
        mv[alloc_row_index] = 1;
        ts[alloc_row_index] = seq;
        seq++;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs.
  task automatic cyc(input bit ae, input int r, input logic [N-1:0] req,
                     input bit fu, input bit fl, input bit rs);
    rst             = rs;
    alloc_en        = ae;
    alloc_row_index = W'(r);
    request_vector  = req;
    fu_ready        = fu;
    flush           = fl;
    model_step();
    @(posedge clk);
    #1;
    check("issue_valid", int'(issue_valid), int'(m_iv));
    check("issue_row_index", int'(issue_row_index), m_idx);
    check("free_en", int'(free_en), int'(m_iv));
    check("free_row_index", int'(free_row_index), m_idx);
    check("alloc_err", int'(alloc_err), int'(m_err));
  endtask

  initial begin
    seq = 1;
    // Reset state
    cyc(0, 0, '0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0);

    // Oldest-first: allocate 3, 1, 6 then drain
    cyc(1, 3, 8'b0100_1010, 0, 0, 0);
    cyc(1, 1, 8'b0100_1010, 0, 0, 0);
    cyc(1, 6, 8'b0100_1010, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'b0100_1010, 1, 0, 0);

    // Stall: two rows requesting with fu_ready low, then release
    cyc(1, 2, 8'b0000_0101, 0, 0, 0);
    cyc(1, 0, 8'b0000_0101, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'b0000_0101, 0, 0, 0);
    cyc(0, 0, 8'b0000_0101, 1, 0, 0);

    // Stale request: row 2 was granted, keep request high; re-allocate it
    cyc(1, 7, 8'b1000_0101, 1, 0, 0);
    cyc(1, 2, 8'b1000_0101, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'b1000_0101, 1, 0, 0);

    // Simultaneous alloc of 5 with grant of 0 (rows 0 and 4 valid)
    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 4, '0, 0, 0, 0);
    cyc(1, 5, 8'b0011_0001, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 8'b0011_0001, 1, 0, 0);

    // Illegal alloc then flush while three rows request
    cyc(1, 1, '0, 0, 0, 0);
    cyc(1, 3, '0, 0, 0, 0);
    cyc(1, 6, '0, 0, 0, 0);
    cyc(1, 1, '0, 0, 0, 0);
    cyc(0, 0, 8'b0100_1010, 1, 0, 0);
    cyc(0, 0, 8'b0100_1010, 1, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 8'hFF, 1, 0, 0);

    // Synchronous reset mid-stream
    cyc(1, 4, 8'hFF, 1, 0, 0);
    cyc(1, 5, 8'hFF, 1, 0, 0);
    cyc(0, 0, 8'hFF, 1, 0, 1);
    cyc(0, 0, 8'hFF, 1, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom % 3) != 0, int'($urandom % N), N'($urandom),
          ($urandom % 4) != 0, ($urandom % 60) == 0, ($urandom % 150) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_issue_select

`default_nettype wire
